// File: rtl/sd_card_pkg.sv
// Shared types and constants for the SD card-side DAT transmitter.
// Optional build macro SD_CARD_DAT_CRC_INJECT_EN is consumed by sd_card_dat_tx.
package sd_card_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NAC,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_END,
        ST_GAP
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam int MIN_GAP_BITS_DEFAULT = 2;

    // Rearranges a payload word so byte0 sits in the top bits and leaves first.
    function automatic logic [31:0] wire_order(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sd_card_dat_tx_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1), one bit per enable; clear has priority.
module card_dat_crc16
    import sd_card_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((bit_i ^ crc_q[15]) ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_card_dat_tx.sv
// Card-side DAT transmitter: start bit, payload, per-lane CRC16, end bit, 1/4-bit mode.
// Define SD_CARD_DAT_CRC_INJECT_EN to add crc_inject_i (corrupts DAT0's last CRC bit).
module sd_card_dat_tx
    import sd_card_pkg::*;
#(
    parameter int MaxBlockBitSize = 10,
    parameter int MinGapBits      = MIN_GAP_BITS_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       sd_clk_en_i,
    input  logic                       start_i,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
    input  logic [15:0]                block_count_i,
    input  logic                       bus_width_is_4_i,
    input  logic [7:0]                 nac_i,
    input  logic                       stop_i,
`ifdef SD_CARD_DAT_CRC_INJECT_EN
    input  logic                       crc_inject_i,
`endif
    input  logic [31:0]                data_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    output logic [3:0]                 dat_o,
    output logic                       dat_en_o,
    output logic                       busy_o,
    output logic                       block_done_o,
    output logic                       done_o,
    output logic                       underrun_o,
    output state_e                     state_o
);

    localparam int CntW = MaxBlockBitSize + 3;
    localparam logic [7:0] GapLoad = (MinGapBits > 0) ? 8'(MinGapBits - 1) : 8'd0;

    state_e                     state_q, state_d;
    logic [MaxBlockBitSize-1:0] size_q, size_d;
    logic                       w4_q, w4_d;
    logic [7:0]                 nac_cnt_q, nac_cnt_d;
    logic [15:0]                blk_left_q, blk_left_d;
    logic [CntW-1:0]            data_left_q, data_left_d;
    logic [4:0]                 word_left_q, word_left_d;
    logic [31:0]                sh_q, sh_d;
    logic [3:0]                 crc_bit_q, crc_bit_d;
    logic [7:0]                 gap_q, gap_d;
    logic [3:0]                 dat_q, dat_d;
    logic                       dat_en_q, dat_en_d;
    logic                       block_done_q, block_done_d;
    logic                       done_q, done_d;
    logic                       underrun_q, underrun_d;
    logic                       stop_req_q, stop_req_d;
    logic                       stopping_q, stopping_d;
    logic                       inject_q, inject_d;

    logic [CntW-1:0] total_bits;
    logic            load_word;
    logic [31:0]     shift_src;
    logic [3:0]      lanes;
    logic [3:0]      crc_idx;
    logic            crc_lane0_bit;
    logic [3:0]      crc_nib;
    logic [3:0]      start_nib;
    logic            crc_clr;
    logic            crc_en;
    logic [15:0]     crc_lane [4];

    for (genvar l = 0; l < 4; l++) begin : g_crc
        card_dat_crc16 u_crc (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (crc_clr),
            .en_i   (crc_en),
            .bit_i  (lanes[l]),
            .crc_o  (crc_lane[l])
        );
    end

    assign total_bits = w4_q ? {2'b00, size_q, 1'b0} : {size_q, 3'b000};
    // A new word is fetched at the first data bit of a block and whenever the last one ran dry.
    assign load_word  = (state_q == ST_START) || (word_left_q == 5'd0);
    assign shift_src  = load_word ? wire_order(data_valid_i ? data_i : 32'hFFFF_FFFF) : sh_q;
    assign lanes      = w4_q ? shift_src[31:28] : {3'b111, shift_src[31]};
    assign crc_idx    = (state_q == ST_CRC) ? crc_bit_q - 4'd1 : 4'd15;
    assign crc_lane0_bit = crc_lane[0][crc_idx] ^ (inject_q && (crc_idx == 4'd0));
    assign crc_nib    = w4_q ? {crc_lane[3][crc_idx], crc_lane[2][crc_idx],
                                crc_lane[1][crc_idx], crc_lane0_bit}
                             : {3'b111, crc_lane0_bit};
    assign start_nib  = w4_q ? 4'h0 : 4'hE;

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        w4_d         = w4_q;
        nac_cnt_d    = nac_cnt_q;
        blk_left_d   = blk_left_q;
        data_left_d  = data_left_q;
        word_left_d  = word_left_q;
        sh_d         = sh_q;
        crc_bit_d    = crc_bit_q;
        gap_d        = gap_q;
        dat_d        = dat_q;
        dat_en_d     = dat_en_q;
        block_done_d = 1'b0;
        done_d       = 1'b0;
        underrun_d   = underrun_q;
        stop_req_d   = stop_req_q | (stop_i && (state_q != ST_IDLE));
        stopping_d   = stopping_q;
        inject_d     = inject_q;
        data_ready_o = 1'b0;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;

        if (sd_clk_en_i) begin
            if (stopping_q) begin
                state_d    = ST_IDLE;
                stopping_d = 1'b0;
                stop_req_d = 1'b0;
                dat_en_d   = 1'b0;
                dat_d      = 4'hF;
                done_d     = 1'b0 | 1'b1;
            end else if ((state_q != ST_IDLE) && (stop_i || stop_req_q)) begin
                // Abort: one all-ones bit time, then release; no partial CRC.
                stopping_d = 1'b1;
                stop_req_d = 1'b0;
                dat_d      = 4'hF;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_i && (block_size_i != '0)) begin
                            size_d     = block_size_i;
                            w4_d       = bus_width_is_4_i;
                            blk_left_d = block_count_i;
                            nac_cnt_d  = nac_i;
                            underrun_d = 1'b0;
                            stop_req_d = 1'b0;
                            state_d    = ST_NAC;
`ifdef SD_CARD_DAT_CRC_INJECT_EN
                            inject_d   = crc_inject_i;
`else
                            inject_d   = 1'b0;
`endif
                        end
                    end
                    ST_NAC, ST_GAP: begin
                        if ((state_q == ST_NAC) ? (nac_cnt_q == 8'd0) : (gap_q == 8'd0)) begin
                            state_d  = ST_START;
                            dat_d    = start_nib;
                            dat_en_d = 1'b1;
                            crc_clr  = 1'b1;
                        end else if (state_q == ST_NAC) begin
                            nac_cnt_d = nac_cnt_q - 8'd1;
                        end else begin
                            gap_d = gap_q - 8'd1;
                        end
                    end
                    ST_START, ST_DATA: begin
                        if ((state_q == ST_START) || (data_left_q != '0)) begin
                            state_d     = ST_DATA;
                            data_left_d = (state_q == ST_START) ? total_bits - 1'b1
                                                                : data_left_q - 1'b1;
                            dat_d       = lanes;
                            crc_en      = 1'b1;
                            sh_d        = w4_q ? {shift_src[27:0], 4'h0} : {shift_src[30:0], 1'b0};
                            word_left_d = load_word ? (w4_q ? 5'd7 : 5'd31) : word_left_q - 5'd1;
                            if (load_word) begin
                                if (data_valid_i) begin
                                    data_ready_o = 1'b1;
                                end else begin
                                    underrun_d = 1'b1;
                                end
                            end
                        end else begin
                            state_d   = ST_CRC;
                            crc_bit_d = 4'd15;
                            dat_d     = crc_nib;
                        end
                    end
                    ST_CRC: begin
                        if (crc_bit_q != 4'd0) begin
                            crc_bit_d = crc_bit_q - 4'd1;
                            dat_d     = crc_nib;
                        end else begin
                            state_d = ST_END;
                            dat_d   = 4'hF;
                        end
                    end
                    ST_END: begin
                        block_done_d = 1'b1;
                        dat_d        = 4'hF;
                        if (blk_left_q == 16'd1) begin
                            state_d  = ST_IDLE;
                            dat_en_d = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            // A count of 0 means unlimited and is never decremented.
                            if (blk_left_q != 16'd0) begin
                                blk_left_d = blk_left_q - 16'd1;
                            end
                            if (MinGapBits == 0) begin
                                state_d = ST_START;
                                dat_d   = start_nib;
                                crc_clr = 1'b1;
                            end else begin
                                state_d = ST_GAP;
                                gap_d   = GapLoad;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            size_q       <= '0;
            w4_q         <= 1'b0;
            nac_cnt_q    <= '0;
            blk_left_q   <= '0;
            data_left_q  <= '0;
            word_left_q  <= '0;
            sh_q         <= '0;
            crc_bit_q    <= '0;
            gap_q        <= '0;
            dat_q        <= 4'hF;
            dat_en_q     <= 1'b0;
            block_done_q <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            stop_req_q   <= 1'b0;
            stopping_q   <= 1'b0;
            inject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            w4_q         <= w4_d;
            nac_cnt_q    <= nac_cnt_d;
            blk_left_q   <= blk_left_d;
            data_left_q  <= data_left_d;
            word_left_q  <= word_left_d;
            sh_q         <= sh_d;
            crc_bit_q    <= crc_bit_d;
            gap_q        <= gap_d;
            dat_q        <= dat_d;
            dat_en_q     <= dat_en_d;
            block_done_q <= block_done_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
            stop_req_q   <= stop_req_d;
            stopping_q   <= stopping_d;
            inject_q     <= inject_d;
        end
    end

    assign dat_o        = dat_q;
    assign dat_en_o     = dat_en_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign block_done_o = block_done_q;
    assign done_o       = done_q;
    assign underrun_o   = underrun_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_sd_card_dat_tx.sv
// Directed self-checking bench for sd_card_dat_tx (default build, 2-clock bit time).
`timescale 1ns/1ps
module tb_sd_card_dat_tx;
    import sd_card_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sd_clk_en;
    logic        start;
    logic [9:0]  block_size;
    logic [15:0] block_count;
    logic        bus_w4;
    logic [7:0]  nac;
    logic        stop;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [3:0]  dat;
    logic        dat_en;
    logic        busy;
    logic        block_done;
    logic        done;
    logic        underrun;
    state_e      state_dbg;

    int total = 0;
    int bad = 0;

    logic [3:0]  rec_q[$];
    logic [3:0]  exp_q[$];
    logic [31:0] word_mem[16];
    logic [31:0] exp_words[16];
    int consumed, bd_cnt, done_cnt, nac_cnt, tick;
    bit ur_gate;

    sd_card_dat_tx dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .sd_clk_en_i      (sd_clk_en),
        .start_i          (start),
        .block_size_i     (block_size),
        .block_count_i    (block_count),
        .bus_width_is_4_i (bus_w4),
        .nac_i            (nac),
        .stop_i           (stop),
        .data_i           (data),
        .data_valid_i     (data_valid),
        .data_ready_o     (data_ready),
        .dat_o            (dat),
        .dat_en_o         (dat_en),
        .busy_o           (busy),
        .block_done_o     (block_done),
        .done_o           (done),
        .underrun_o       (underrun),
        .state_o          (state_dbg)
    );

    always #5 clk = ~clk;

    // Bit-time strobe every second clock plus the payload source, updated just after each edge.
    always @(posedge clk) begin
        #1;
        tick = tick + 1;
        sd_clk_en = (tick % 2 == 1);
        data = word_mem[consumed % 16];
        data_valid = !(ur_gate && consumed == 1 && !underrun);
    end

    // Each strobe cycle closes one bit time; record what was driven during it.
    always @(negedge clk) begin
        if (data_ready) consumed = consumed + 1;
        if (block_done) bd_cnt = bd_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
        if (sd_clk_en) begin
            if (dat_en) rec_q.push_back(dat);
            else if (busy) nac_cnt = nac_cnt + 1;
        end
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
    endfunction

    function automatic int stream_diffs(output int first);
        int n = 0;
        first = -1;
        for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
            if (rec_q[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return n;
    endfunction

    task automatic clear_mon();
        rec_q.delete();
        exp_q.delete();
        consumed = 0;
        bd_cnt = 0;
        done_cnt = 0;
        nac_cnt = 0;
    endtask

    // Frame expectation from exp_words: start bit, payload, per-lane CRC, end bit.
    task automatic push_frame(input int size, input bit w4);
        logic [15:0] crc[4];
        logic [7:0]  b;
        logic [3:0]  nib;
        for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
        exp_q.push_back(w4 ? 4'h0 : 4'hE);
        for (int i = 0; i < size; i++) begin
            b = exp_words[i / 4][8 * (i % 4) +: 8];
            if (w4) begin
                for (int h = 1; h >= 0; h--) begin
                    nib = b[4 * h +: 4];
                    exp_q.push_back(nib);
                    for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], nib[l]);
                end
            end else begin
                for (int k = 7; k >= 0; k--) begin
                    exp_q.push_back({3'b111, b[k]});
                    crc[0] = crc_step(crc[0], b[k]);
                end
            end
        end
        for (int i = 15; i >= 0; i--) begin
            exp_q.push_back(w4 ? {crc[3][i], crc[2][i], crc[1][i], crc[0][i]} : {3'b111, crc[0][i]});
        end
        exp_q.push_back(4'hF);
    endtask

    task automatic start_xfer(input int size, input int count, input bit w4, input int nac_v);
        @(posedge clk) #2;
        block_size = 10'(size);
        block_count = 16'(count);
        bus_w4 = w4;
        nac = 8'(nac_v);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk) #2;
            if (busy) break;
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if ({dat, dat_en, busy, underrun, done, block_done, data_ready} !== {4'hF, 6'b0}) begin
            bad++;
            $display("FAIL reset_values: got %b want %b",
                     {dat, dat_en, busy, underrun, done, block_done, data_ready}, {4'hF, 6'b0});
        end
        @(posedge clk) #2;
        rst_n = 1'b1;
    endtask

    task automatic test_zero_size();
        clear_mon();
        start_xfer(0, 1, 0, 0);
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_size_busy: got %b want 0", busy);
        end
        total++;
        if (rec_q.size() != 0) begin
            bad++;
            $display("FAIL zero_size_bus: got %0d driven bit times want 0", rec_q.size());
        end
    endtask

    task automatic test_1bit_ones();
        bit ok;
        int first, n;
        logic [15:0] crc_ref;
        crc_ref = 16'h7FA1;
        for (int i = 0; i < 16; i++) word_mem[i] = 32'hFFFF_FFFF;
        clear_mon();
        exp_q.push_back(4'hE);
        repeat (4096) exp_q.push_back(4'hF);
        for (int i = 15; i >= 0; i--) exp_q.push_back({3'b111, crc_ref[i]});
        exp_q.push_back(4'hF);
        start_xfer(512, 1, 0, 0);
        wait_done(20000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ones_done_timeout: got no done want done"); end
        total++;
        if (rec_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL ones_len: got %0d bit times want %0d", rec_q.size(), exp_q.size());
        end
        n = stream_diffs(first);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL ones_stream: %0d differ, first at %0d got %h want %h", n, first, rec_q[first], exp_q[first]);
        end
        total++;
        if (bd_cnt != 1) begin bad++; $display("FAIL ones_block_done: got %0d want 1", bd_cnt); end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL ones_done_cnt: got %0d want 1", done_cnt); end
        total++;
        if (consumed != 128) begin bad++; $display("FAIL ones_words: got %0d want 128", consumed); end
        total++;
        if (nac_cnt != 1) begin bad++; $display("FAIL ones_nac0: got %0d want 1", nac_cnt); end
        total++;
        if ({busy, dat_en} !== 2'b00) begin bad++; $display("FAIL ones_idle: got %b want 00", {busy, dat_en}); end
    endtask

    task automatic test_4bit_nibbles();
        bit ok;
        int first, n;
        logic [15:0] l3, l2, l1, l0;
        logic [7:0]  got_first;
        l3 = 16'h9188; l2 = 16'h48C4; l1 = 16'h9188; l0 = 16'h48C4;
        word_mem[0] = 32'h0000_00A5;
        clear_mon();
        exp_q.push_back(4'h0);
        exp_q.push_back(4'hA);
        exp_q.push_back(4'h5);
        repeat (6) exp_q.push_back(4'h0);
        for (int i = 15; i >= 0; i--) exp_q.push_back({l3[i], l2[i], l1[i], l0[i]});
        exp_q.push_back(4'hF);
        start_xfer(4, 1, 1, 2);
        wait_done(500, ok);
        total++;
        if (!ok || rec_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL nib_len: got %0d bit times (done=%b) want %0d", rec_q.size(), ok, exp_q.size());
        end
        got_first = (rec_q.size() >= 3) ? {rec_q[1], rec_q[2]} : 8'h00;
        total++;
        if (got_first !== 8'hA5) begin bad++; $display("FAIL nib_first: got %h want a5", got_first); end
        n = stream_diffs(first);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL nib_stream: %0d differ, first at %0d got %h want %h", n, first, rec_q[first], exp_q[first]);
        end
        total++;
        if (nac_cnt != 3) begin bad++; $display("FAIL nib_nac2: got %0d want 3", nac_cnt); end
        total++;
        if (consumed != 1) begin bad++; $display("FAIL nib_words: got %0d want 1", consumed); end
    endtask

    task automatic test_multi_block();
        bit ok;
        int first, n;
        for (int i = 0; i < 16; i++) word_mem[i] = 32'hA5C3_0F00 ^ (i * 32'h0102_0304);
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            exp_words[0] = word_mem[2 * k];
            exp_words[1] = word_mem[2 * k + 1];
            push_frame(8, 1);
            if (k < 2) begin
                exp_q.push_back(4'hF);
                exp_q.push_back(4'hF);
            end
        end
        start_xfer(8, 3, 1, 1);
        wait_done(1000, ok);
        total++;
        if (!ok || rec_q.size() != 106) begin
            bad++;
            $display("FAIL multi_len: got %0d bit times (done=%b) want 106", rec_q.size(), ok);
        end
        n = stream_diffs(first);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL multi_stream: %0d differ, first at %0d got %h want %h", n, first, rec_q[first], exp_q[first]);
        end
        total++;
        if (bd_cnt != 3) begin bad++; $display("FAIL multi_block_done: got %0d want 3", bd_cnt); end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL multi_done: got %0d want 1", done_cnt); end
        total++;
        if (consumed != 6) begin bad++; $display("FAIL multi_words: got %0d want 6", consumed); end
    endtask

    task automatic test_underrun();
        bit ok;
        int first, n;
        word_mem[0] = 32'h1234_5678;
        word_mem[1] = 32'h0F0F_00FF;
        word_mem[2] = 32'hDEAD_BEEF;
        word_mem[3] = 32'h5555_AAAA;
        clear_mon();
        exp_words[0] = 32'h1234_5678;
        exp_words[1] = 32'hFFFF_FFFF;
        exp_words[2] = 32'h0F0F_00FF;
        exp_words[3] = 32'hDEAD_BEEF;
        push_frame(16, 0);
        ur_gate = 1'b1;
        start_xfer(16, 1, 0, 0);
        wait_done(1000, ok);
        ur_gate = 1'b0;
        n = stream_diffs(first);
        total++;
        if (!ok || n != 0 || rec_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL ur_stream: %0d differ, first at %0d, len %0d want %0d", n, first, rec_q.size(), exp_q.size());
        end
        total++;
        if (underrun !== 1'b1) begin bad++; $display("FAIL ur_flag: got %b want 1", underrun); end
        total++;
        if (consumed != 3) begin bad++; $display("FAIL ur_words: got %0d want 3", consumed); end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL ur_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stop();
        bit ok, seen;
        int l0, c0;
        logic [7:0] tail;
        for (int i = 0; i < 16; i++) word_mem[i] = 32'h0000_0000;
        clear_mon();
        start_xfer(16, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk) #2;
            if (rec_q.size() >= 10) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL stop_reach_data: got %0d bit times want 10", rec_q.size()); end
        stop = 1'b1;
        l0 = rec_q.size();
        c0 = consumed;
        @(posedge clk) #2;
        stop = 1'b0;
        wait_done(200, ok);
        total++;
        if (!ok || rec_q.size() != l0 + 2) begin
            bad++;
            $display("FAIL stop_len: got %0d bit times (done=%b) want %0d", rec_q.size(), ok, l0 + 2);
        end
        tail = (rec_q.size() >= l0 + 2) ? {rec_q[l0], rec_q[l0 + 1]} : 8'h00;
        total++;
        if (tail !== 8'hEF) begin bad++; $display("FAIL stop_tail: got %h want ef", tail); end
        total++;
        if (consumed != c0) begin bad++; $display("FAIL stop_words: got %0d want %0d", consumed, c0); end
        total++;
        if (done_cnt != 1 || bd_cnt != 0) begin
            bad++;
            $display("FAIL stop_pulses: got done=%0d block_done=%0d want 1 0", done_cnt, bd_cnt);
        end
        total++;
        if ({busy, dat_en, dat} !== 6'b00_1111) begin
            bad++;
            $display("FAIL stop_idle: got %b want 001111", {busy, dat_en, dat});
        end
    endtask

    task automatic test_reset_in_crc();
        bit seen;
        for (int i = 0; i < 16; i++) word_mem[i] = 32'h3C3C_3C3C;
        clear_mon();
        start_xfer(4, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk) #2;
            if (state_dbg == ST_CRC) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rst_reach_crc: got state %0d want crc", state_dbg); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({dat_en, dat, busy} !== 6'b0_1111_0) begin
            bad++;
            $display("FAIL rst_crc_release: got %b want 011110", {dat_en, dat, busy});
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt != 0) begin bad++; $display("FAIL rst_no_done: got %0d want 0", done_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        sd_clk_en = 1'b0;
        start = 1'b0;
        block_size = '0;
        block_count = '0;
        bus_w4 = 1'b0;
        nac = '0;
        stop = 1'b0;
        data = '0;
        data_valid = 1'b0;
        tick = 0;
        ur_gate = 1'b0;
        for (int i = 0; i < 16; i++) word_mem[i] = 32'h0;
        clear_mon();

        test_reset();
        test_zero_size();
        test_1bit_ones();
        test_4bit_nibbles();
        test_multi_block();
        test_underrun();
        test_stop();
        test_reset_in_crc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
